// File: rtl/sfp_loopback_model_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sfp_loopback_model_if
//  Description : Word-level link bundle between a transmitting/receiving
//                agent (master) and the SFP loopback channel model (slave).
//                Ports:
//                  tx_data/tx_valid   - per-lane words entering the channel
//                  lat                - delay-line latency select (lat+1)
//                  mode               - 00/11 pass, 01 LOS, 10 error inject
//                  sfp_txd            - transmit disable (acts as LOS)
//                  err_period/mask    - error injection controls
//                  rx_data/rx_valid   - per-lane words leaving the channel
//                  sfp_sgd            - signal detect
//                  err_count          - saturating injected-error total
//  Revision    : 1.0 - initial release
// ============================================================================
interface sfp_loopback_model_if #(
    parameter int LANES = 1,
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int c_aw = $clog2(DEPTH);

    logic [LANES*WIDTH-1:0] tx_data;
    logic [LANES-1:0]       tx_valid;
    logic [c_aw-1:0]        lat;
    logic [1:0]             mode;
    logic                   sfp_txd;
    logic [15:0]            err_period;
    logic [WIDTH-1:0]       err_mask;
    logic [LANES*WIDTH-1:0] rx_data;
    logic [LANES-1:0]       rx_valid;
    logic                   sfp_sgd;
    logic [15:0]            err_count;

    modport master (
        output tx_data, tx_valid, lat, mode, sfp_txd, err_period, err_mask,
        input  rx_data, rx_valid, sfp_sgd, err_count
    );

    modport slave (
        input  tx_data, tx_valid, lat, mode, sfp_txd, err_period, err_mask,
        output rx_data, rx_valid, sfp_sgd, err_count
    );
endinterface
`default_nettype wire

// File: rtl/sfp_loopback_model.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sfp_loopback_model
//  Description : Clocked multi-lane loopback channel. Each lane is a circular
//                delay line of DEPTH entries with latency lat+1 cycles. Adds
//                loss-of-signal emulation, SFP signal-detect timing and
//                periodic bit-error injection on lane-0 word cadence.
//                Ports:
//                  CLK    - single clock, rising edge
//                  RESET  - asynchronous, active-high reset
//                  lnk    - slave side of sfp_loopback_model_if (tx words in,
//                           rx words / sfp_sgd / err_count out, controls)
//                Module parameters must match those of the connected
//                interface instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module sfp_loopback_model #(
    parameter int LANES     = 1,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int SGD_DELAY = 64
) (
    input  wire logic            CLK,
    input  wire logic            RESET,
    sfp_loopback_model_if.slave  lnk
);
    localparam int c_aw = $clog2(DEPTH);
    localparam int c_fw = c_aw + 1;
    localparam int c_sw = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int c_gw = $clog2(SGD_DELAY + 1);

    localparam logic [c_fw-1:0] c_flush_load = c_fw'(DEPTH);
    localparam logic [c_gw-1:0] c_gc_target  = c_gw'(SGD_DELAY);
    localparam logic [c_sw-1:0] c_sel_last   = c_sw'(LANES - 1);
    localparam logic [1:0]      c_mode_los   = 2'b01;
    localparam logic [1:0]      c_mode_err   = 2'b10;

    // Shared control state
    logic [c_aw-1:0] r_wp;
    logic [c_aw-1:0] r_lat_q;
    logic [c_fw-1:0] r_flush;
    logic [c_gw-1:0] r_gc;
    logic            r_sgd;
    logic [15:0]     r_wc;
    logic [c_sw-1:0] r_sel;
    logic [15:0]     r_err_count;

    logic            w_down;
    logic [c_aw-1:0] w_rd_addr;
    logic [16:0]     w_wc_inc;
    logic            w_inj_act;
    logic            w_inj_hit;
    logic            w_inject;
    logic [15:0]     w_wc_next;

    assign w_down = lnk.sfp_txd || (lnk.mode == c_mode_los);

    // The write at this edge lands at r_wp, so the entry written lat+1 edges
    // ago sits at r_wp-lat-1. Using the registered latency keeps the edge on
    // which lat changes reading with the old latency; the flush window that
    // follows hides the transition.
    assign w_rd_addr = r_wp - r_lat_q - c_aw'(1);

    // Error-inject cadence: count valid lane-0 words; fire on the
    // err_period-th. A firing while the link is down still restarts the
    // count, but nothing corrupted is written and nothing is counted.
    always_comb begin
        w_wc_inc  = {1'b0, r_wc} + 17'd1;
        w_inj_act = (lnk.mode == c_mode_err) && (lnk.err_period != 16'd0);
        w_inj_hit = w_inj_act && lnk.tx_valid[0] &&
                    (w_wc_inc >= {1'b0, lnk.err_period});
        w_inject  = w_inj_hit && !w_down;
        w_wc_next = r_wc;
        if (!w_inj_act) begin
            w_wc_next = 16'd0;
        end else if (lnk.tx_valid[0]) begin
            w_wc_next = w_inj_hit ? 16'd0 : w_wc_inc[15:0];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wp        <= '0;
            r_lat_q     <= '0;
            r_flush     <= c_flush_load;
            r_gc        <= '0;
            r_sgd       <= 1'b0;
            r_wc        <= 16'd0;
            r_sel       <= '0;
            r_err_count <= 16'd0;
        end else begin
            r_wp    <= r_wp + c_aw'(1);
            r_lat_q <= lnk.lat;

            if (lnk.lat != r_lat_q) begin
                r_flush <= c_flush_load;
            end else if (r_flush != '0) begin
                r_flush <= r_flush - c_fw'(1);
            end

            // Signal detect: any down cycle restarts the full good-run count.
            if (w_down) begin
                r_gc <= '0;
            end else if (r_gc != c_gc_target) begin
                r_gc <= r_gc + c_gw'(1);
            end
            r_sgd <= !w_down && (r_gc == c_gc_target);

            r_wc <= w_wc_next;
            if (w_inject) begin
                r_sel <= (r_sel == c_sel_last) ? '0 : r_sel + c_sw'(1);
                if (r_err_count != 16'hFFFF) begin
                    r_err_count <= r_err_count + 16'd1;
                end
            end
        end
    end

    assign lnk.sfp_sgd   = r_sgd;
    assign lnk.err_count = r_err_count;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [DEPTH-1:0] r_mem_v;
        logic [WIDTH-1:0] r_rx_word;
        logic             r_rx_v;
        logic             w_corrupt;
        logic [WIDTH-1:0] w_wr_data;
        logic             w_wr_valid;

        assign w_corrupt  = w_inject && (r_sel == c_sw'(k));
        assign w_wr_data  = w_down ? '0 :
                            (lnk.tx_data[k*WIDTH +: WIDTH] ^
                             (w_corrupt ? lnk.err_mask : '0));
        assign w_wr_valid = !w_down && lnk.tx_valid[k];

        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_mem[i] <= '0;
                end
                r_mem_v   <= '0;
                r_rx_word <= '0;
                r_rx_v    <= 1'b0;
            end else begin
                r_mem[r_wp]   <= w_wr_data;
                r_mem_v[r_wp] <= w_wr_valid;
                r_rx_word     <= r_mem[w_rd_addr];
                // Only valid is suppressed while flushing; data stays visible.
                r_rx_v        <= r_mem_v[w_rd_addr] && (r_flush == '0);
            end
        end

        assign lnk.rx_data[k*WIDTH +: WIDTH] = r_rx_word;
        assign lnk.rx_valid[k]               = r_rx_v;
    end
endmodule
`default_nettype wire

// File: tb/tb_sfp_loopback_model.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sfp_loopback_model
//  Description : Self-checking bench for sfp_loopback_model (2 lanes, 8-bit,
//                DEPTH 16, SGD_DELAY 64). A history-based reference model
//                predicts every output each cycle; directed sequences cover
//                latency, signal detect, LOS, injection, flush and
//                saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sfp_loopback_model;
    localparam int LANES = 2;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int SGD   = 64;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    sfp_loopback_model_if #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) lnk ();

    sfp_loopback_model #(
        .LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH), .SGD_DELAY(SGD)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .lnk   (lnk)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: what was written on each edge since reset.
    int n = 0, rst_edge = 0, chg_edge = 0, latq = 0;
    int run = 0, wcnt = 0, sel = 0, ecnt = 0;
    logic [LANES*WIDTH-1:0] hd [64];
    logic [LANES-1:0]       hv [64];
    logic [LANES*WIDTH-1:0] exp_data;
    logic [LANES-1:0]       exp_valid;
    logic                   exp_sgd;
    logic [7:0]             drv [32];

    typedef struct {
        logic [3:0] lat;
        logic [7:0] data;
        int         exp_cycles;
    } probe_t;
    probe_t probes [5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s edge=%0d got=%h expected=%h", name, n, got, want);
        end
    endtask

    task automatic step(input bit chk_en);
        int m;
        bit down, act, hit;
        logic [LANES*WIDTH-1:0] wd;
        logic [LANES-1:0]       wv;
        down = lnk.sfp_txd || (lnk.mode == 2'b01);
        n++;
        m = n - latq - 1;
        if (m > rst_edge) begin
            exp_data  = hd[m % 64];
            exp_valid = hv[m % 64];
        end else begin
            exp_data  = '0;
            exp_valid = '0;
        end
        if (n <= chg_edge + DEPTH) exp_valid = '0;
        exp_sgd = !down && (run >= SGD);
        run = down ? 0 : run + 1;
        act = (lnk.mode == 2'b10) && (lnk.err_period != 16'd0);
        hit = 1'b0;
        if (!act) wcnt = 0;
        else if (lnk.tx_valid[0]) begin
            wcnt++;
            if (wcnt >= int'(lnk.err_period)) begin
                wcnt = 0;
                hit  = 1'b1;
            end
        end
        wd = lnk.tx_data;
        wv = lnk.tx_valid;
        if (hit && !down) begin
            wd[sel*WIDTH +: WIDTH] = wd[sel*WIDTH +: WIDTH] ^ lnk.err_mask;
            if (ecnt < 65535) ecnt++;
            sel = (sel + 1) % LANES;
        end
        if (down) begin
            wd = '0;
            wv = '0;
        end
        hd[n % 64] = wd;
        hv[n % 64] = wv;
        if (int'(lnk.lat) != latq) begin
            chg_edge = n;
            latq     = int'(lnk.lat);
        end
        @(posedge CLK);
        #1;
        if (chk_en) begin
            check("rx_data",   32'(lnk.rx_data),   32'(exp_data));
            check("rx_valid",  32'(lnk.rx_valid),  32'(exp_valid));
            check("sfp_sgd",   32'(lnk.sfp_sgd),   32'(exp_sgd));
            check("err_count", 32'(lnk.err_count), 32'(ecnt));
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        check("reset_rx_data",   32'(lnk.rx_data),   32'd0);
        check("reset_rx_valid",  32'(lnk.rx_valid),  32'd0);
        check("reset_sgd",       32'(lnk.sfp_sgd),   32'd0);
        check("reset_err_count", 32'(lnk.err_count), 32'd0);
        rst_edge = n; chg_edge = n; latq = 0;
        run = 0; wcnt = 0; sel = 0; ecnt = 0;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    // Drive byte b on both lanes with valid, remembering it by edge index.
    task automatic stream(input logic [7:0] b, input bit chk_en);
        lnk.tx_data  = {b, b};
        lnk.tx_valid = 2'b11;
        drv[(n + 1) % 32] = b;
        step(chk_en);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog edge=%0d got=timeout expected=finish", n);
        $fatal(1, "watchdog");
    end

    initial begin
        probes[0] = '{lat: 4'd0,  data: 8'h3C, exp_cycles: 1};
        probes[1] = '{lat: 4'd3,  data: 8'hA1, exp_cycles: 4};
        probes[2] = '{lat: 4'd7,  data: 8'h5E, exp_cycles: 8};
        probes[3] = '{lat: 4'd9,  data: 8'hC7, exp_cycles: 10};
        probes[4] = '{lat: 4'd15, data: 8'h96, exp_cycles: 16};

        lnk.tx_data = '0; lnk.tx_valid = '0; lnk.lat = 4'd3; lnk.mode = 2'b00;
        lnk.sfp_txd = 1'b0; lnk.err_period = 16'd0; lnk.err_mask = 8'h00;
        do_reset();

        // Signal detect after reset, then a one-cycle transmit-disable glitch.
        for (int i = 1; i <= 70; i++) begin
            stream(8'(i), 1'b1);
            check("sgd_rise", 32'(lnk.sfp_sgd), 32'(i >= 65));
        end
        lnk.sfp_txd = 1'b1;
        stream(8'h77, 1'b1);
        check("sgd_glitch_fall", 32'(lnk.sfp_sgd), 32'd0);
        lnk.sfp_txd = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            stream(8'(i), 1'b1);
            check("sgd_recover", 32'(lnk.sfp_sgd), 32'(i >= 65));
        end

        // Table-driven latency probes.
        for (int p = 0; p < 5; p++) begin
            int  cnt;
            bit  found;
            lnk.lat = probes[p].lat;
            lnk.tx_valid = '0;
            repeat (DEPTH + 2) step(1'b1);
            lnk.tx_data  = {probes[p].data, probes[p].data};
            lnk.tx_valid = 2'b11;
            step(1'b1);
            lnk.tx_valid = '0;
            cnt = 0; found = 1'b0;
            while (!found && cnt < 40) begin
                step(1'b1);
                cnt++;
                if (lnk.rx_valid[0]) found = 1'b1;
            end
            check("lat_probe_cycles", 32'(cnt), 32'(probes[p].exp_cycles));
            check("lat_probe_data", 32'(lnk.rx_data[7:0]), 32'(probes[p].data));
        end

        // Pass-through at lat=3: incrementing bytes return 4 cycles later.
        lnk.lat = 4'd3; lnk.tx_valid = '0;
        repeat (DEPTH + 2) step(1'b1);
        for (int i = 0; i < 24; i++) begin
            stream(8'(i), 1'b1);
            if (i >= 4) begin
                check("pass_valid", 32'(lnk.rx_valid), 32'h3);
                check("pass_data",  32'(lnk.rx_data), 32'({8'(i - 4), 8'(i - 4)}));
            end
        end

        // LOS at lat=7: 8 in-flight words drain, then silence, then resume.
        lnk.lat = 4'd7;
        for (int i = 0; i < 30; i++) stream(8'(i), 1'b1);
        lnk.mode = 2'b01;
        for (int i = 1; i <= 20; i++) begin
            stream(8'(i), 1'b1);
            check("los_drain", 32'(lnk.rx_valid), (i <= 8) ? 32'h3 : 32'h0);
        end
        lnk.mode = 2'b00;
        for (int i = 1; i <= 20; i++) begin
            stream(8'(i), 1'b1);
            check("los_resume", 32'(lnk.rx_valid), (i <= 8) ? 32'h0 : 32'h3);
        end

        // Error injection: period 4, mask 01, lanes alternate 0,1,0.
        lnk.mode = 2'b10; lnk.err_period = 16'd4; lnk.err_mask = 8'h01;
        for (int s = 1; s <= 20; s++) begin
            lnk.tx_data  = {8'(8'h50 + s), 8'(8'h10 + s)};
            lnk.tx_valid = (s <= 12) ? 2'b11 : 2'b00;
            step(1'b1);
            if (s == 12) check("inj_count", 32'(lnk.err_count), 32'd3);
            if (s > 8) begin
                int w;
                w = s - 8;
                check("inj_lane0", 32'(lnk.rx_data[7:0]),
                      32'(8'(8'h10 + w) ^ ((w == 4 || w == 12) ? 8'h01 : 8'h00)));
                check("inj_lane1", 32'(lnk.rx_data[15:8]),
                      32'(8'(8'h50 + w) ^ ((w == 8) ? 8'h01 : 8'h00)));
            end
        end
        lnk.mode = 2'b00; lnk.err_period = 16'd0;

        // Latency change 2 -> 9: exactly 16 masked cycles, then 10-cycle latency.
        lnk.lat = 4'd2;
        for (int i = 0; i < 24; i++) stream(8'(8'h80 + i), 1'b1);
        lnk.lat = 4'd9;
        stream(8'hE0, 1'b1);
        check("latchg_edge", 32'(lnk.rx_valid), 32'h3);
        for (int i = 1; i <= 16; i++) begin
            stream(8'(8'hE0 + i), 1'b1);
            check("latchg_flush", 32'(lnk.rx_valid), 32'h0);
        end
        for (int i = 1; i <= 10; i++) begin
            stream(8'(8'hF0 + i), 1'b1);
            check("latchg_valid", 32'(lnk.rx_valid), 32'h3);
            check("latchg_data", 32'(lnk.rx_data[7:0]), 32'(drv[(n - 10) % 32]));
        end

        // Reset mid-stream: nothing valid emerges for a full flush window.
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            stream(8'(i), 1'b1);
            check("reset_quiet", 32'(lnk.rx_valid), 32'h0);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            lnk.tx_data  = 16'($urandom);
            lnk.tx_valid = 2'($urandom);
            if ($urandom_range(0, 49) == 0) lnk.mode = 2'($urandom_range(0, 3));
            lnk.sfp_txd = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 199) == 0) lnk.lat = 4'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                lnk.err_period = 16'($urandom_range(0, 5));
                lnk.err_mask   = 8'($urandom);
            end
            step(1'b1);
        end

        // Saturation: one injection per cycle well past 16'hFFFF.
        lnk.sfp_txd = 1'b0; lnk.mode = 2'b00; lnk.err_period = 16'd1;
        lnk.err_mask = 8'hFF; lnk.lat = 4'd0;
        do_reset();
        lnk.mode = 2'b10; lnk.tx_valid = 2'b11;
        repeat (65540) step(1'b0);
        step(1'b1);
        check("sat_err_count", 32'(lnk.err_count), 32'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
